mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port instr, input, 32 bits: instruction register contents.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory has completed the current request.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port ImmSrc, output, 3 bits: sign-extender select (000 I, 001 S, 010 B, 011 none, 100 U, 101 J).
REQ-007 SHALL have ports mem_req and mem_we, output, 1 bit each: memory request, write enable.
REQ-008 SHALL have ports ir_write, pc_write and reg_write, output, 1 bit each: register enables.
REQ-009 SHALL have ports alu_src_a, alu_src_b, alu_op and result_src, output, 2 bits each: datapath mux and ALU-class selects.
REQ-010 SHALL have ports instr_done and halted, output, 1 bit each: instr_done is a one-cycle retire pulse; halted is a sticky trap flag.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, UPPER and TRAP.
REQ-012 FETCH SHALL assert mem_req and hold it until mem_ready; in the cycle where mem_ready=1 it SHALL pulse ir_write and pc_write (PC+4) and go to DECODE. Otherwise it SHALL stay in FETCH.
REQ-013 DECODE SHALL classify instr[6:0]. The next state SHALL be:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- 1101111 -> JAL
- 0110111 or 0010111 -> UPPER
- any other opcode -> TRAP
REQ-014 ImmSrc SHALL be decoded from instr[6:0] in every state except FETCH and TRAP, where it SHALL be 011. The mapping SHALL be: load/I-ALU 000, store 001, branch 010, R-type 011, LUI/AUIPC 100, JAL 101.
REQ-015 MEMADR SHALL go to MEMRD for a load and to MEMWR for a store.
REQ-016 MEMRD and MEMWR SHALL hold mem_req (and mem_we in MEMWR) until mem_ready. Then MEMRD SHALL go to MEMWB, and MEMWR SHALL go to FETCH with instr_done=1.
REQ-017 MEMWB, ALUWB and UPPER SHALL assert reg_write for exactly one cycle, pulse instr_done, and go to FETCH.
REQ-018 EXEC_R and EXEC_I SHALL go to ALUWB. JAL SHALL assert pc_write (target PC+imm) and go to ALUWB, which writes back PC+4.
REQ-019 BRANCH SHALL assert pc_write if (funct3=000 and zero=1) or (funct3=001 and zero=0), pulse instr_done, and go to FETCH. Any other funct3 SHALL go to TRAP.
REQ-020 TRAP SHALL assert halted, drive all enables to 0, and remain in TRAP until reset.
REQ-021 Latencies with zero memory wait SHALL be: R/I/UPPER 3-4 cycles, load 5, store 4, branch 3.
REQ-022 Each memory wait cycle SHALL add exactly one cycle and leave all other outputs unchanged.
REQ-023 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-024 rst_n=0 SHALL immediately force state FETCH, halted=0 and all enables/pulses to 0, including when asserted mid-transaction.
REQ-025 In the first cycle after release the block SHALL drive mem_req=1 and ImmSrc=011.

Structure
REQ-026 The state enum, opcode constants and ImmSrc encodings SHALL be defined in the shared package ctrl_pkg.
REQ-027 Opcode classification SHALL be implemented in a combinational sub-module opcode_decoder, instantiated once.

Verification
REQ-028 instr=0x00500093 (addi), mem_ready=1 -> FETCH, DECODE, EXEC_I, ALUWB; ImmSrc=000; reg_write and instr_done high in cycle 4.
REQ-029 instr=0x00112223 (sw), mem_ready low for 3 cycles in MEMWR -> mem_we held 4 cycles, ImmSrc=001, instr_done on the ready cycle.
REQ-030 instr=0x00000463 (beq) with zero=1, and then with zero=0 -> ImmSrc=010; pc_write=1 in BRANCH only when zero=1.
REQ-031 instr=0x00000000 -> TRAP; halted stays 1 for 10 cycles; mem_req=0.
REQ-032 rst_n pulsed low during MEMRD -> outputs clear asynchronously; after release the FSM is in FETCH with mem_req=1.
REQ-033 instr=0x0000006F (jal) -> ImmSrc=101; pc_write in the JAL state and reg_write in ALUWB.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle controller: FSM states,
// opcode values, immediate-select codes and datapath mux encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC_R  = 4'd6,
    EXEC_I  = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    JAL     = 4'd10,
    UPPER   = 4'd11,
    TRAP    = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_LOAD    = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_RTYPE   = 3'd2,
    CLS_ITYPE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_UPPER   = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_NONE = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  // ALU operand A: current PC, PC of the instruction being executed, rs1
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  // ALU operand B: rs2, extended immediate, constant 4
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // ALU class: add, subtract (branch compare), decode from funct fields
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Result bus: registered ALU output, memory read data, live ALU result, immediate
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: instruction class and immediate format.
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_src
);

  // Map the 7-bit opcode onto an instruction class and its immediate format
  always_comb begin
    op_class = CLS_ILLEGAL;
    imm_src  = IMM_NONE;
    case (opcode)
      OP_LOAD:   begin op_class = CLS_LOAD;   imm_src = IMM_I; end
      OP_STORE:  begin op_class = CLS_STORE;  imm_src = IMM_S; end
      OP_RTYPE:  begin op_class = CLS_RTYPE;  imm_src = IMM_NONE; end
      OP_ITYPE:  begin op_class = CLS_ITYPE;  imm_src = IMM_I; end
      OP_BRANCH: begin op_class = CLS_BRANCH; imm_src = IMM_B; end
      OP_JAL:    begin op_class = CLS_JAL;    imm_src = IMM_J; end
      OP_LUI:    begin op_class = CLS_UPPER;  imm_src = IMM_U; end
      OP_AUIPC:  begin op_class = CLS_UPPER;  imm_src = IMM_U; end
      default:   begin op_class = CLS_ILLEGAL; imm_src = IMM_NONE; end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V style control FSM.
//
//   state  | meaning
//   FETCH  | read instruction memory; on ready load IR and advance PC by 4
//   DECODE | classify opcode; ALU precomputes PC+imm into ALUOut
//   MEMADR | compute load/store address rs1+imm
//   MEMRD  | issue data read, wait for ready
//   MEMWB  | write load data into rd
//   MEMWR  | issue data write, wait for ready, retire
//   EXEC_R | register-register ALU operation
//   EXEC_I | register-immediate ALU operation
//   ALUWB  | write ALUOut into rd, retire
//   BRANCH | compare rs1/rs2, take target from ALUOut if condition holds
//   JAL    | load PC with target, ALU forms PC+4 for the link register
//   UPPER  | write LUI immediate or AUIPC sum into rd, retire
//   TRAP   | illegal instruction; everything idle until reset
module mc_controller
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [2:0]  ImmSrc,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        instr_done,
  output logic        halted
);

  state_t     state;
  state_t     state_next;
  op_class_t  op_class;
  logic [2:0] imm_dec;
  logic [2:0] funct3;
  logic       unused_instr;

  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  opcode_decoder u_opcode_decoder (
    .opcode   (instr[6:0]),
    .op_class (op_class),
    .imm_src  (imm_dec)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // Next-state and output decode; outputs are forced idle while reset is held
  always_comb begin
    state_next = state;
    ImmSrc     = IMM_NONE;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    instr_done = 1'b0;
    halted     = 1'b0;

    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op_class)
          CLS_LOAD, CLS_STORE: state_next = MEMADR;
          CLS_RTYPE:           state_next = EXEC_R;
          CLS_ITYPE:           state_next = EXEC_I;
          CLS_BRANCH:          state_next = BRANCH;
          CLS_JAL:             state_next = JAL;
          CLS_UPPER:           state_next = UPPER;
          default:             state_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        state_next = (op_class == CLS_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_FUNCT;
        state_next = ALUWB;
      end
      EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_SUB;
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          pc_write   = (funct3 == F3_BEQ) ? zero : !zero;
          instr_done = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = TRAP;
        end
      end
      JAL: begin
        // Target PC+imm was latched into ALUOut during DECODE
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      UPPER: begin
        // LUI writes the immediate; AUIPC writes PC+imm formed in DECODE
        result_src = instr[5] ? RES_IMM : RES_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      TRAP: begin
        halted = 1'b1;
      end
      default: begin
        state_next = TRAP;
      end
    endcase

    if (state != FETCH && state != TRAP) ImmSrc = imm_dec;

    if (!rst_n) begin
      ImmSrc     = IMM_NONE;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks addi, sw with wait states, beq
// taken/not taken, jal, lw with a mid-read reset, add, lui and an illegal trap.
module tb_mc_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic [2:0]  ImmSrc;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  result_src;
  logic        instr_done;
  logic        halted;

  int checks;
  int errors;
  int we_cnt;

  mc_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .ImmSrc     (ImmSrc),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .instr_done (instr_done),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    we_cnt    = 0;
    rst_n     = 1'b0;
    instr     = 32'h0050_0093;
    mem_ready = 1'b1;
    zero      = 1'b0;

    // reset held across a clock edge
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_halted", halted, 0);
    chk("rst_immsrc", ImmSrc, 3'b011);

    // addi: FETCH, DECODE, EXEC_I, ALUWB
    rst_n = 1'b1;
    #1;
    chk("addi_fetch_mem_req", mem_req, 1);
    chk("addi_fetch_immsrc", ImmSrc, 3'b011);
    chk("addi_fetch_ir_write", ir_write, 1);
    chk("addi_fetch_pc_write", pc_write, 1);
    tick();
    chk("addi_dec_immsrc", ImmSrc, 3'b000);
    chk("addi_dec_mem_req", mem_req, 0);
    chk("addi_dec_ir_write", ir_write, 0);
    tick();
    chk("addi_exec_reg_write", reg_write, 0);
    chk("addi_exec_immsrc", ImmSrc, 3'b000);
    tick();
    chk("addi_wb_reg_write", reg_write, 1);
    chk("addi_wb_instr_done", instr_done, 1);
    tick();
    chk("addi_back_fetch", mem_req, 1);
    chk("addi_back_reg_write", reg_write, 0);

    // sw with three wait cycles in MEMWR
    instr = 32'h0011_2223;
    tick();
    chk("sw_dec_immsrc", ImmSrc, 3'b001);
    tick();
    chk("sw_adr_mem_we", mem_we, 0);
    chk("sw_adr_mem_req", mem_req, 0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (mem_we) we_cnt++;
      chk("sw_wait_mem_req", mem_req, 1);
      chk("sw_wait_instr_done", instr_done, 0);
      chk("sw_wait_immsrc", ImmSrc, 3'b001);
      if (i == 2) mem_ready = 1'b1;
      else        tick();
      if (i == 2) #1;
    end
    if (mem_we) we_cnt++;
    chk("sw_ready_instr_done", instr_done, 1);
    chk("sw_we_cycles", we_cnt, 4);
    tick();
    chk("sw_back_fetch_mem_req", mem_req, 1);
    chk("sw_back_fetch_mem_we", mem_we, 0);

    // beq taken
    instr = 32'h0000_0463;
    zero  = 1'b1;
    tick();
    chk("beq1_dec_immsrc", ImmSrc, 3'b010);
    chk("beq1_dec_pc_write", pc_write, 0);
    tick();
    chk("beq1_pc_write", pc_write, 1);
    chk("beq1_instr_done", instr_done, 1);
    chk("beq1_immsrc", ImmSrc, 3'b010);
    tick();
    chk("beq1_back_fetch", mem_req, 1);

    // beq not taken
    zero = 1'b0;
    tick();
    chk("beq0_dec_immsrc", ImmSrc, 3'b010);
    tick();
    chk("beq0_pc_write", pc_write, 0);
    chk("beq0_instr_done", instr_done, 1);
    tick();
    chk("beq0_back_fetch", mem_req, 1);

    // jal
    instr = 32'h0000_006F;
    tick();
    chk("jal_dec_immsrc", ImmSrc, 3'b101);
    tick();
    chk("jal_pc_write", pc_write, 1);
    chk("jal_reg_write", reg_write, 0);
    tick();
    chk("jal_wb_reg_write", reg_write, 1);
    chk("jal_wb_pc_write", pc_write, 0);
    chk("jal_wb_instr_done", instr_done, 1);
    tick();
    chk("jal_back_fetch", mem_req, 1);

    // lw interrupted by reset while in MEMRD
    instr = 32'h0001_2083;
    tick();
    chk("lw_dec_immsrc", ImmSrc, 3'b000);
    tick();
    mem_ready = 1'b0;
    tick();
    chk("lw_rd_mem_req", mem_req, 1);
    chk("lw_rd_mem_we", mem_we, 0);
    rst_n = 1'b0;
    #1;
    chk("lw_async_mem_req", mem_req, 0);
    chk("lw_async_immsrc", ImmSrc, 3'b011);
    tick();
    chk("lw_rst_held_mem_req", mem_req, 0);
    rst_n = 1'b1;
    #1;
    chk("lw_release_mem_req", mem_req, 1);
    chk("lw_release_immsrc", ImmSrc, 3'b011);
    chk("lw_release_ir_write", ir_write, 0);

    // lw complete, zero-wait: 5 cycles
    mem_ready = 1'b1;
    #1;
    chk("lw_fetch_ir_write", ir_write, 1);
    tick();
    tick();
    tick();
    chk("lw_memrd_mem_req", mem_req, 1);
    chk("lw_memrd_reg_write", reg_write, 0);
    tick();
    chk("lw_wb_reg_write", reg_write, 1);
    chk("lw_wb_instr_done", instr_done, 1);
    chk("lw_wb_result_src", result_src, 2'b01);
    tick();
    chk("lw_back_fetch", mem_req, 1);

    // add (R-type)
    instr = 32'h0020_81B3;
    tick();
    chk("add_dec_immsrc", ImmSrc, 3'b011);
    tick();
    chk("add_exec_alu_op", alu_op, 2'b10);
    tick();
    chk("add_wb_reg_write", reg_write, 1);
    tick();

    // lui: 3 cycles
    instr = 32'h0000_10B7;
    tick();
    chk("lui_dec_immsrc", ImmSrc, 3'b100);
    tick();
    chk("lui_reg_write", reg_write, 1);
    chk("lui_instr_done", instr_done, 1);
    tick();
    chk("lui_back_fetch", mem_req, 1);

    // illegal opcode -> TRAP, sticky
    instr = 32'h0000_0000;
    tick();
    chk("trap_dec_immsrc", ImmSrc, 3'b011);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("trap_halted", halted, 1);
      chk("trap_mem_req", mem_req, 0);
      chk("trap_pc_write", pc_write, 0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("trap_rst_halted", halted, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
